// File: rtl/cdb_pkg.sv
// Shared types and defaults for the buffered CDB arbiter.
package cdb_pkg;
    localparam int CDB_DATA_W = 20;
    localparam int CDB_TC_W   = 2;

    // Conventional channel assignment
    localparam int CH_INT = 0;
    localparam int CH_LS  = 1;
    localparam int CH_MUL = 2;

    typedef struct packed {
        logic                  valid;
        logic [CDB_DATA_W-1:0] payload;
    } cdb_entry_t;

    typedef struct packed {
        logic [CDB_DATA_W-1:0] payload;
        logic [CDB_TC_W-1:0]   tc;
    } fu_result_t;
endpackage

// File: rtl/cdb_chan_fifo.sv
// Per-channel result FIFO: power-of-two depth, flush wins over push/pop.
module cdb_chan_fifo #(
    parameter int W     = 22,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    // Storage array; contents are don't-care until a pointer covers them
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/cdb_arbiter_buffered.sv
// Buffered multi-slot CDB arbiter: per-channel FIFOs feed up to NUM_SLOTS
// registered broadcast slots per cycle. Fixed priority (channel 0 highest)
// by default; define CDB_RR_ARB_EN for a rotating round-robin pointer.
module cdb_arbiter_buffered
    import cdb_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int NUM_SLOTS  = 2,
    parameter int DATA_W     = CDB_DATA_W,
    parameter int TC_W       = CDB_TC_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic [NUM_CH-1:0]                    ch_valid,
    output logic [NUM_CH-1:0]                    ch_ready,
    input  logic [NUM_CH*DATA_W-1:0]             ch_data,
    input  logic [NUM_CH*TC_W-1:0]               ch_tc,
    output logic [NUM_SLOTS*(DATA_W+1)-1:0]      cdb_data,
    output logic [NUM_SLOTS*TC_W-1:0]            cdb_tc,
    output logic [NUM_SLOTS*$clog2(NUM_CH)-1:0]  cdb_src,
    output logic [NUM_CH-1:0]                    clear_rs,
    output logic [NUM_CH-1:0]                    fifo_full
);
    localparam int SRC_W = $clog2(NUM_CH);
    localparam int ENT_W = DATA_W + TC_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_CH-1:0][ENT_W-1:0]    head;
    logic [NUM_CH-1:0][CNT_W-1:0]    count;
    logic [NUM_CH-1:0]               empty, push, pop;
    logic [NUM_SLOTS-1:0]            slot_vld;
    logic [NUM_SLOTS-1:0][SRC_W-1:0] slot_src;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Ready comes from registered occupancy only, so a full FIFO stays
        // closed even in a cycle where its head is being popped.
        assign ch_ready[i] = (count[i] < CNT_W'(FIFO_DEPTH));
        assign push[i]     = ch_valid[i] & ch_ready[i];

        cdb_chan_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .push  (push[i]),
            .pop   (pop[i]),
            .wdata ({ch_data[i*DATA_W +: DATA_W], ch_tc[i*TC_W +: TC_W]}),
            .rdata (head[i]),
            .count (count[i]),
            .full  (fifo_full[i]),
            .empty (empty[i])
        );
    end

`ifdef CDB_RR_ARB_EN
    logic [SRC_W-1:0] rr_ptr, rr_next, last_src;

    // Next pointer: one past the channel in the highest filled slot
    always_comb begin
        last_src = '0;
        for (int s = 0; s < NUM_SLOTS; s++)
            if (slot_vld[s]) last_src = slot_src[s];
        rr_next = (int'(last_src) == NUM_CH - 1) ? '0 : last_src + 1'b1;
    end

    // Rotating priority pointer, advanced only on cycles with a grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          rr_ptr <= '0;
        else if (flush)      rr_ptr <= '0;
        else if (|slot_vld)  rr_ptr <= rr_next;
    end
`endif

    // Fill slots in order, each taking the best remaining non-empty channel
    always_comb begin
        logic [NUM_CH-1:0] avail;
        int c;
        avail    = ~empty;
        slot_vld = '0;
        slot_src = '0;
        pop      = '0;
        c        = 0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            for (int k = 0; k < NUM_CH; k++) begin
`ifdef CDB_RR_ARB_EN
                c = int'(rr_ptr) + k;
                if (c >= NUM_CH) c = c - NUM_CH;
`else
                c = k;
`endif
                if (!slot_vld[s] && avail[c]) begin
                    slot_vld[s] = 1'b1;
                    slot_src[s] = SRC_W'(c);
                    avail[c]    = 1'b0;
                    pop[c]      = 1'b1;
                end
            end
        end
    end

    // Registered CDB slots and RS clear pulses; unfilled slots are all-zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_data <= '0;
            cdb_tc   <= '0;
            cdb_src  <= '0;
            clear_rs <= '0;
        end else if (flush) begin
            cdb_data <= '0;
            cdb_tc   <= '0;
            cdb_src  <= '0;
            clear_rs <= '0;
        end else begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                cdb_data[s*(DATA_W+1) +: DATA_W+1] <= slot_vld[s] ?
                    {1'b1, head[slot_src[s]][ENT_W-1:TC_W]} : '0;
                cdb_tc[s*TC_W +: TC_W] <= slot_vld[s] ?
                    head[slot_src[s]][TC_W-1:0] : '0;
            end
            cdb_src  <= slot_src;
            clear_rs <= pop;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter_buffered.sv
// Directed table-driven bench for cdb_arbiter_buffered (default build).
module tb_cdb_arbiter_buffered;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [2:0]  ch_valid;
    logic [2:0]  ch_ready;
    logic [59:0] ch_data;
    logic [5:0]  ch_tc;
    logic [41:0] cdb_data;
    logic [3:0]  cdb_tc;
    logic [3:0]  cdb_src;
    logic [2:0]  clear_rs;
    logic [2:0]  fifo_full;

    int n_chk  = 0;
    int n_fail = 0;

    cdb_arbiter_buffered dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .ch_valid  (ch_valid),
        .ch_ready  (ch_ready),
        .ch_data   (ch_data),
        .ch_tc     (ch_tc),
        .cdb_data  (cdb_data),
        .cdb_tc    (cdb_tc),
        .cdb_src   (cdb_src),
        .clear_rs  (clear_rs),
        .fifo_full (fifo_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  vld;
        logic [59:0] data;
        logic [5:0]  tc;
        logic        fl;
        logic [41:0] e_data;
        logic [3:0]  e_tc;
        logic [3:0]  e_src;
        logic [2:0]  e_clr;
        logic [2:0]  e_rdy;
        logic [2:0]  e_full;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string nm, logic [2:0] vld,
                                logic [19:0] d0, logic [19:0] d1, logic [19:0] d2,
                                logic [5:0] tci, logic fl, logic [1:0] ev,
                                logic [19:0] p0, logic [19:0] p1, logic [3:0] etc,
                                logic [3:0] esrc, logic [2:0] clr, logic [2:0] rdy,
                                logic [2:0] full);
        vec_t v;
        v.name   = nm;
        v.vld    = vld;
        v.data   = {d2, d1, d0};
        v.tc     = tci;
        v.fl     = fl;
        v.e_data = {ev[1], p1, ev[0], p0};
        v.e_tc   = etc;
        v.e_src  = esrc;
        v.e_clr  = clr;
        v.e_rdy  = rdy;
        v.e_full = full;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(string nm, logic [41:0] d, logic [3:0] t, logic [3:0] s,
                            logic [2:0] c, logic [2:0] r, logic [2:0] f);
        chk({nm, ".cdb_data"},  64'(cdb_data),  64'(d));
        chk({nm, ".cdb_tc"},    64'(cdb_tc),    64'(t));
        chk({nm, ".cdb_src"},   64'(cdb_src),   64'(s));
        chk({nm, ".clear_rs"},  64'(clear_rs),  64'(c));
        chk({nm, ".ch_ready"},  64'(ch_ready),  64'(r));
        chk({nm, ".fifo_full"}, 64'(fifo_full), 64'(f));
    endtask

    task automatic drive(logic [2:0] v, logic [59:0] d, logic [5:0] t, logic fl);
        ch_valid = v;
        ch_data  = d;
        ch_tc    = t;
        flush    = fl;
    endtask

    localparam logic [5:0] TC3 = 6'b11_10_01;  // ch2=11, ch1=10, ch0=01

    initial begin
        rst_n = 1'b0;
        drive(3'b000, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", '0, '0, '0, 3'b000, 3'b111, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        // name vld d0 d1 d2 tcin flush | ev p0 p1 etc esrc clr rdy full
        tbl.push_back(mk("push3",   3'b111, 20'h00011, 20'h00022, 20'h00033, TC3, 0,
                         2'b00, 20'h0, 20'h0, 4'b0000, 4'b0000, 3'b000, 3'b111, 3'b000));
        tbl.push_back(mk("bcast01", 3'b000, 20'h0, 20'h0, 20'h0, 6'b0, 0,
                         2'b11, 20'h00011, 20'h00022, 4'b10_01, 4'b01_00, 3'b011, 3'b111, 3'b000));
        tbl.push_back(mk("bcast2",  3'b000, 20'h0, 20'h0, 20'h0, 6'b0, 0,
                         2'b01, 20'h00033, 20'h0, 4'b00_11, 4'b00_10, 3'b100, 3'b111, 3'b000));
        tbl.push_back(mk("idle1",   3'b000, 20'h0, 20'h0, 20'h0, 6'b0, 0,
                         2'b00, 20'h0, 20'h0, 4'b0, 4'b0, 3'b000, 3'b111, 3'b000));
        tbl.push_back(mk("mulpush", 3'b100, 20'h0, 20'h0, 20'h0ABCD, 6'b10_00_00, 0,
                         2'b00, 20'h0, 20'h0, 4'b0, 4'b0, 3'b000, 3'b111, 3'b000));
        tbl.push_back(mk("mulout",  3'b000, 20'h0, 20'h0, 20'h0, 6'b0, 0,
                         2'b01, 20'h0ABCD, 20'h0, 4'b00_10, 4'b00_10, 3'b100, 3'b111, 3'b000));
        tbl.push_back(mk("idle2",   3'b000, 20'h0, 20'h0, 20'h0, 6'b0, 0,
                         2'b00, 20'h0, 20'h0, 4'b0, 4'b0, 3'b000, 3'b111, 3'b000));
        // Streaming: ch0/ch1 hold both slots, ch2 fills and is starved
        tbl.push_back(mk("strm0",   3'b111, 20'h0A000, 20'h0B000, 20'h0C000, TC3, 0,
                         2'b00, 20'h0, 20'h0, 4'b0, 4'b0, 3'b000, 3'b111, 3'b000));
        tbl.push_back(mk("strm1",   3'b111, 20'h0A001, 20'h0B001, 20'h0C001, TC3, 0,
                         2'b11, 20'h0A000, 20'h0B000, 4'b10_01, 4'b01_00, 3'b011, 3'b011, 3'b100));
        tbl.push_back(mk("strm2",   3'b111, 20'h0A002, 20'h0B002, 20'h0C002, TC3, 0,
                         2'b11, 20'h0A001, 20'h0B001, 4'b10_01, 4'b01_00, 3'b011, 3'b011, 3'b100));
        tbl.push_back(mk("strm3",   3'b111, 20'h0A003, 20'h0B003, 20'h0C003, TC3, 0,
                         2'b11, 20'h0A002, 20'h0B002, 4'b10_01, 4'b01_00, 3'b011, 3'b011, 3'b100));
        tbl.push_back(mk("strm4",   3'b100, 20'h0, 20'h0, 20'h0DEAD, TC3, 0,
                         2'b11, 20'h0A003, 20'h0B003, 4'b10_01, 4'b01_00, 3'b011, 3'b011, 3'b100));
        // Full ch2 popped while valid: push refused that cycle
        tbl.push_back(mk("fullpop", 3'b100, 20'h0, 20'h0, 20'h0BEEF, TC3, 0,
                         2'b01, 20'h0C000, 20'h0, 4'b00_11, 4'b00_10, 3'b100, 3'b111, 3'b000));
        tbl.push_back(mk("drain",   3'b000, 20'h0, 20'h0, 20'h0, 6'b0, 0,
                         2'b01, 20'h0C001, 20'h0, 4'b00_11, 4'b00_10, 3'b100, 3'b111, 3'b000));
        tbl.push_back(mk("nostale", 3'b000, 20'h0, 20'h0, 20'h0, 6'b0, 0,
                         2'b00, 20'h0, 20'h0, 4'b0, 4'b0, 3'b000, 3'b111, 3'b000));
        // Flush with four entries buffered plus a same-cycle push
        tbl.push_back(mk("fill0",   3'b111, 20'h0E000, 20'h0F000, 20'h0D000, TC3, 0,
                         2'b00, 20'h0, 20'h0, 4'b0, 4'b0, 3'b000, 3'b111, 3'b000));
        tbl.push_back(mk("fill1",   3'b111, 20'h0E001, 20'h0F001, 20'h0D001, TC3, 0,
                         2'b11, 20'h0E000, 20'h0F000, 4'b10_01, 4'b01_00, 3'b011, 3'b011, 3'b100));
        tbl.push_back(mk("flush",   3'b111, 20'h0E002, 20'h0F002, 20'h0D002, TC3, 1,
                         2'b00, 20'h0, 20'h0, 4'b0, 4'b0, 3'b000, 3'b111, 3'b000));
        tbl.push_back(mk("postfl1", 3'b000, 20'h0, 20'h0, 20'h0, 6'b0, 0,
                         2'b00, 20'h0, 20'h0, 4'b0, 4'b0, 3'b000, 3'b111, 3'b000));
        tbl.push_back(mk("postfl2", 3'b000, 20'h0, 20'h0, 20'h0, 6'b0, 0,
                         2'b00, 20'h0, 20'h0, 4'b0, 4'b0, 3'b000, 3'b111, 3'b000));

        foreach (tbl[i]) begin
            drive(tbl[i].vld, tbl[i].data, tbl[i].tc, tbl[i].fl);
            @(posedge clk);
            #1;
            chk_outs(tbl[i].name, tbl[i].e_data, tbl[i].e_tc, tbl[i].e_src,
                     tbl[i].e_clr, tbl[i].e_rdy, tbl[i].e_full);
        end

        // Asynchronous reset in the middle of traffic
        drive(3'b111, {20'h00300, 20'h00200, 20'h00100}, TC3, 1'b0);
        @(posedge clk);
        #1;
        drive(3'b111, {20'h00301, 20'h00201, 20'h00101}, TC3, 1'b0);
        @(posedge clk);
        #1;
        chk_outs("prerst", {1'b1, 20'h00200, 1'b1, 20'h00100}, 4'b10_01, 4'b01_00,
                 3'b011, 3'b011, 3'b100);
        drive(3'b000, '0, '0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("midrst", '0, '0, '0, 3'b000, 3'b111, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_outs("postrst", '0, '0, '0, 3'b000, 3'b111, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
